axis_upsizer: RTL

- Packs narrow AXI4-Stream words into wide words; the inverse companion of the team's downsizer.
- Typical placement is between an ADC/DSP sample stream and a DMA/FIFO or wide-bus consumer.
- The number of narrow words per wide beat is runtime-configurable.
- Unused upper lanes of a wide beat are zero-filled.

---
 rtl/axis_upsizer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs narrow AXI4-Stream words into wide beats.
// The number of narrow words per beat is set at runtime by cfg_data, and
// lanes above the last used one are zero-filled.
// Optional feature macro: AXIS_UPSIZER_TLAST_EN adds cfg_length / m_axis_tlast
// and a beat counter that marks the last beat of each packet.

module axis_upsizer #(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [15:0]                   cfg_data,
`ifdef AXIS_UPSIZER_TLAST_EN
    input  logic [15:0]                   cfg_length,
    output logic                          m_axis_tlast,
`endif
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int unsigned RATIO      = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
    localparam int unsigned CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNTR_WIDTH-1:0] LAST_MAX = CNTR_WIDTH'(RATIO - 1);

    logic [CNTR_WIDTH-1:0]         cntr_q;
    logic [M_AXIS_TDATA_WIDTH-1:0] acc_q;
    logic [M_AXIS_TDATA_WIDTH-1:0] acc_wr;
    logic [M_AXIS_TDATA_WIDTH-1:0] beat_word;
    logic [CNTR_WIDTH-1:0]         cfg_lane;
    logic [CNTR_WIDTH-1:0]         last_eff;
    logic                          complete;
    logic                          accept;
    logic                          final_accept;

    // Only the low CNTR_WIDTH bits of cfg_data matter; the rest are ignored.
    logic unused_cfg;
    assign unused_cfg = ^cfg_data;

    // Beat-close decision; >= lets a mid-beat shrink of cfg_data close the beat.
    always_comb begin
        cfg_lane     = cfg_data[CNTR_WIDTH-1:0];
        last_eff     = (cfg_lane > LAST_MAX) ? LAST_MAX : cfg_lane;
        complete     = (cntr_q >= last_eff);
        accept       = s_axis_tvalid & s_axis_tready;
        final_accept = accept & complete;
    end

    // Non-final words never need the output register, so only a final word waits.
    assign s_axis_tready = ~complete | ~m_axis_tvalid | m_axis_tready;

    // Lane steering: accumulator write for non-final words, assembled beat for final ones.
    always_comb begin
        acc_wr    = acc_q;
        beat_word = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (k < 32'(cntr_q)) begin
                beat_word[k*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] =
                    acc_q[k*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH];
            end else if (k == 32'(cntr_q)) begin
                beat_word[k*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = s_axis_tdata;
            end
            if (k == 32'(cntr_q)) begin
                acc_wr[k*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = s_axis_tdata;
            end
        end
    end

    // Lane counter and accumulator; cleared after every beat so no stale lanes remain.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cntr_q <= '0;
            acc_q  <= '0;
        end else if (accept) begin
            if (complete) begin
                cntr_q <= '0;
                acc_q  <= '0;
            end else begin
                cntr_q <= cntr_q + CNTR_WIDTH'(1);
                acc_q  <= acc_wr;
            end
        end
    end

`ifdef AXIS_UPSIZER_TLAST_EN
    logic [15:0] beat_cntr_q;
    logic        beat_last;

    assign beat_last = (beat_cntr_q >= cfg_length);

    // Packet beat counter; wraps on the beat that carries tlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cntr_q <= '0;
        end else if (final_accept) begin
            beat_cntr_q <= beat_last ? 16'd0 : beat_cntr_q + 16'd1;
        end
    end
`endif

    // Output register: reloads on a final accept, even while draining, for full rate.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
            m_axis_tlast  <= 1'b0;
`endif
        end else if (final_accept) begin
            m_axis_tdata  <= beat_word;
            m_axis_tvalid <= 1'b1;
`ifdef AXIS_UPSIZER_TLAST_EN
            m_axis_tlast  <= beat_last;
`endif
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
